// File: rtl/img_frame_reader.sv
// Raster-order frame streamer: reads a frame RAM and emits pixels with sof/eol/eof on valid/ready.
// Define IMG_READER_HMIRROR_EN to read every line right-to-left (horizontal mirror).
module img_frame_reader #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

`ifdef IMG_READER_HMIRROR_EN
    localparam logic [CW-1:0]     COL_FIRST  = COL_LAST;
    localparam logic [CW-1:0]     COL_END    = '0;
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(IMG_W - 1);
`else
    localparam logic [CW-1:0]     COL_FIRST  = '0;
    localparam logic [CW-1:0]     COL_END    = COL_LAST;
    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
`endif

    logic [1:0]        state_q;
    logic [CW-1:0]     col_q, col_nxt;
    logic [RW-1:0]     row_q, row_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              inflight_q;
    logic [2:0]        tag_q, tag;
    logic [DATA_W+2:0] fifo_mem_q [2];
    logic [DATA_W+2:0] head;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              done_q;
    logic              line_end, frame_end, pop, issue;

    always_comb begin
        line_end  = (col_q == COL_END);
        frame_end = line_end && (row_q == ROW_LAST);
        pop       = pix_valid && pix_ready;
        // Outstanding = FIFO entries plus the read still in the RAM pipe; a pop frees one slot now.
        issue     = (state_q == ST_FETCH) &&
                    ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop);
        tag       = {(col_q == COL_FIRST) && (row_q == '0), line_end, frame_end};

        row_nxt = row_q;
`ifdef IMG_READER_HMIRROR_EN
        if (line_end) begin
            col_nxt  = COL_LAST;
            row_nxt  = row_q + RW'(1);
            addr_nxt = addr_q + ADDR_W'(2 * IMG_W - 1);
        end else begin
            col_nxt  = col_q - CW'(1);
            addr_nxt = addr_q - ADDR_W'(1);
        end
`else
        addr_nxt = addr_q + ADDR_W'(1);
        if (line_end) begin
            col_nxt = '0;
            row_nxt = row_q + RW'(1);
        end else begin
            col_nxt = col_q + CW'(1);
        end
`endif
    end

    always_comb begin
        head      = fifo_mem_q[rd_ptr_q];
        pix_valid = (count_q != 2'd0);
        pix_data  = head[DATA_W-1:0];
        pix_sof   = pix_valid && head[DATA_W+2];
        pix_eol   = pix_valid && head[DATA_W+1];
        pix_eof   = pix_valid && head[DATA_W];
        mem_en    = issue;
        mem_addr  = addr_q;
        busy      = (state_q != ST_IDLE);
        done      = done_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            col_q      <= COL_FIRST;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
        end else begin
            done_q <= pop && pix_eof;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        col_q   <= COL_FIRST;
                        row_q   <= '0;
                        addr_q  <= ADDR_FIRST;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        // Last address stays on mem_addr while draining.
                        if (frame_end) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            col_q  <= col_nxt;
                            row_q  <= row_nxt;
                            addr_q <= addr_nxt;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && pix_eof) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            inflight_q <= issue;
            if (issue) tag_q <= tag;

            if (inflight_q) begin
                fifo_mem_q[wr_ptr_q] <= {tag_q, mem_dout};
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;

            if (inflight_q && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (!inflight_q && pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_img_frame_reader.sv
// Randomized self-checking bench for img_frame_reader (IMG_W=4, IMG_H=3, RAM holds mem[a]=a).
module tb_img_frame_reader;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
`ifdef IMG_READER_HMIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        busy, done, mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout = 8'd0;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_ready, pix_sof, pix_eol, pix_eof;

    int n_cmp = 0;
    int n_fail = 0;

    img_frame_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAM with mem[a] = a.
    always @(posedge CLK) if (mem_en) mem_dout <= mem_addr[7:0];

    // Monitor: records accepted pixels and tracks outstanding reads at the stream level.
    logic [10:0] acc_q[$];
    int cyc = 0, issued = 0, accepted = 0, viol = 0, stall_err = 0;
    int done_cnt = 0, eof_cyc = 0, done_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_pix = '0;

    always @(negedge CLK) begin
        logic hs;
        cyc++;
        if (RESET) begin
            issued = 0; accepted = 0; prev_stall = 1'b0;
        end else begin
            hs = pix_valid && pix_ready;
            if (prev_stall && (!pix_valid || {pix_sof, pix_eol, pix_eof, pix_data} !== prev_pix))
                stall_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = {pix_sof, pix_eol, pix_eof, pix_data};
            if (hs) acc_q.push_back({pix_sof, pix_eol, pix_eof, pix_data});
            if (hs && pix_eof) eof_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mem_en) begin
                if (!hs && (issued - accepted) >= 2) viol++;
                issued++;
            end
            if (hs) accepted++;
        end
    end

    function automatic logic [10:0] exp_pix(input int i);
        int idx, r, c, a;
        idx = i % N;
        r   = idx / W;
        c   = idx % W;
        a   = r * W + (MIRROR ? (W - 1 - c) : c);
        return {idx == 0, c == W - 1, idx == N - 1, 8'(a)};
    endfunction

    function automatic logic pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return 1'($urandom % 2);
    endfunction

    task automatic check_frames(input string name, input int nframes);
        n_cmp++;
        if (acc_q.size() !== N * nframes) begin
            n_fail++;
            $display("FAIL %s count: got %0d pixels, want %0d", name, acc_q.size(), N * nframes);
        end
        for (int i = 0; i < acc_q.size() && i < N * nframes; i++) begin
            n_cmp++;
            if (acc_q[i] !== exp_pix(i)) begin
                n_fail++;
                $display("FAIL %s pix[%0d]: got {sof,eol,eof,data}=%h, want %h",
                         name, i, acc_q[i], exp_pix(i));
            end
        end
    endtask

    // Starts a frame and runs until target_done done pulses (bounded), then settles.
    task automatic run_frames(input int mode, input bit mid_start, input bit b2b,
                              input int target_done, input bit chk_lat, input string name);
        int  k;
        bit  sent2, b2b_chk;
        acc_q.delete();
        done_cnt = 0; viol = 0; stall_err = 0;
        @(posedge CLK); #1;
        start = 1'b1; pix_ready = pat(mode, 0);
        k = 0; sent2 = 0; b2b_chk = 0;
        while (k < 600 && done_cnt < target_done) begin
            @(posedge CLK); #1;
            k++;
            start = 1'b0;
            if (chk_lat && k == 1) begin
                n_cmp++;
                if (!(busy === 1'b1 && mem_en === 1'b1 && mem_addr === 16'(exp_pix(0) & 11'hff))) begin
                    n_fail++;
                    $display("FAIL %s first_issue: busy=%b mem_en=%b addr=%0d, want 1 1 %0d",
                             name, busy, mem_en, mem_addr, exp_pix(0) & 11'hff);
                end
            end
            if (chk_lat && (k == 1 || k == 2 || k == 3)) begin
                n_cmp++;
                if (pix_valid !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL %s latency k=%0d: pix_valid=%b, want %b", name, k, pix_valid, k == 3);
                end
            end
            if (b2b_chk) begin
                b2b_chk = 0;
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s b2b_busy: got %b, want 1", name, busy);
                end
            end
            if (mid_start && !sent2 && acc_q.size() >= 5) begin start = 1'b1; sent2 = 1; end
            if (b2b && !sent2 && done === 1'b1) begin start = 1'b1; sent2 = 1; b2b_chk = 1; end
            pix_ready = pat(mode, k);
        end
        n_cmp++;
        if (done_cnt < target_done) begin
            n_fail++;
            $display("FAIL %s timeout: done pulses %0d, want %0d", name, done_cnt, target_done);
        end
        start = 1'b0; pix_ready = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        n_cmp++;
        if (done_cnt !== target_done) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d, want %0d", name, done_cnt, target_done);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL %s issue_rule: %0d over-issues, want 0", name, viol);
        end
        n_cmp++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL %s stall_hold: %0d unstable stalls, want 0", name, stall_err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_busy: got %b, want 0", name, busy);
        end
        check_frames(name, target_done);
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b1; pix_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({busy, done, mem_en, pix_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy,done,mem_en,valid=%b, want 0000",
                     {busy, done, mem_en, pix_valid});
        end
        n_cmp++;
        if (mem_addr !== 16'd0 || pix_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d data=%0d, want 0 0", mem_addr, pix_data);
        end
        n_cmp++;
        if ({pix_sof, pix_eol, pix_eof} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 000", {pix_sof, pix_eol, pix_eof});
        end
        start = 1'b0; RESET = 1'b0;
    endtask

    task automatic test_basic();
        run_frames(0, 1'b0, 1'b0, 1, 1'b1, "basic");
        n_cmp++;
        if (done_cyc - eof_cyc !== 1) begin
            n_fail++;
            $display("FAIL basic done_timing: done %0d cycles after eof, want 1", done_cyc - eof_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        acc_q.delete();
        done_cnt = 0;
        @(posedge CLK); #1;
        start = 1'b1; pix_ready = 1'b1;
        k = 0;
        while (k < 100 && acc_q.size() < 6) begin
            @(posedge CLK); #1;
            start = 1'b0; k++;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        n_cmp++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid state: valid=%b busy=%b mem_en=%b, want 0 0 0",
                     pix_valid, busy, mem_en);
        end
        repeat (10) @(posedge CLK);
        #1;
        n_cmp++;
        if (done_cnt !== 0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid no_done: done=%0d valid=%b, want 0 0", done_cnt, pix_valid);
        end
        run_frames(0, 1'b0, 1'b0, 1, 1'b1, "after_reset");
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; pix_ready = 1'b0;
        test_reset();
        test_basic();
        run_frames(1, 1'b0, 1'b0, 1, 1'b0, "backpressure");
        run_frames(2, 1'b0, 1'b0, 1, 1'b0, "random_ready");
        run_frames(2, 1'b1, 1'b0, 1, 1'b0, "start_busy");
        test_reset_mid();
        run_frames(0, 1'b0, 1'b1, 2, 1'b0, "back_to_back");
        run_frames(2, 1'b0, 1'b1, 2, 1'b0, "b2b_random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
